bcd_updown_counter: RTL
=======================

Name: bcd_updown_counter

Overview:
- Synchronous multi-digit BCD up/down counter with parallel load, enable, and terminal-count output.
- Sits directly upstream of the SN74145 BCD-to-decimal decoder. Each 4-bit digit of q drives one decoder's i[3:0] input.
- Guarantees that only legal BCD codes (0-9) ever reach the decoder. Codes 10-15 are never emitted.

Parameters:
DIGITS, 2, number of cascaded BCD digits; q width is 4*DIGITS; legal range 1-4.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
en  input  1  count enable; count one step per clock when high
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  parallel load strobe, sampled on clk
d  input  4*DIGITS  parallel load value, packed BCD, digit 0 in d[3:0]
clr_err  input  1  clears the sticky err flag
q  output  4*DIGITS  current count, packed BCD, digit 0 in q[3:0]
tc  output  1  terminal count (combinational): en & ((up & all digits 9) | (~up & all digits 0))
err  output  1  sticky flag: an illegal BCD digit was presented on a load

Behaviour:
- All state updates on the rising clk edge. q reflects any action one cycle after the sampling edge.
- Priority per edge, highest first: ~rst_n, then load, then en, then hold.
- Reset (rst_n=0 at an edge):
  - q <= 0 and err <= 0.
  - tc then equals en & ~up.
  - Reset overrides load and en in the same cycle, including mid-count.
- Load (load=1):
  - Each digit k takes d[4k+3:4k] if that digit is <= 9.
  - A digit > 9 is replaced by 0, and err <= 1 on the same edge.
  - Legal digits in the same word still load normally.
  - en is ignored on a load cycle.
- Count up (en=1, up=1, load=0):
  - Digit 0 increments; 9 wraps to 0 and carries into digit 1, rippling upward through all digits in the same cycle.
  - All-9s wraps to all-0s. tc is high during the cycle before the wrap.
- Count down (en=1, up=0, load=0):
  - Digit 0 decrements; 0 wraps to 9 and borrows from digit 1, rippling upward.
  - All-0s wraps to all-9s. tc is high during the cycle before the wrap.
- Hold (en=0, load=0): q is unchanged and tc=0.
- Changing direction takes effect on the next edge with no extra latency, e.g. 45 up then down gives 46 -> 45.
- err:
  - Set by an illegal load digit.
  - Cleared by clr_err=1 at an edge, unless an illegal load occurs on the same edge; set wins.
  - Cleared by reset.
  - err has no effect on counting.
- Carry/borrow chain is purely combinational within the cycle. There is no multi-cycle ripple.
- Invariant: every digit of q is always in 0-9, including after reset, any load, and any wrap.
- tc may be cascaded into another instance's en for extended counts.

Test Plan:
- Reset then count, DIGITS=2:
  - Stimulus: rst_n=0 one cycle, then en=1, up=1 for 12 cycles.
  - Required: q = 0x00, 0x01, ..., 0x09, 0x10, 0x11, 0x12. Nibbles 0xA-0xF never appear.
- Up wrap:
  - Stimulus: load d=0x98, then en=1, up=1.
  - Required: q = 0x98, 0x99 (tc=1), 0x00 (tc=0).
- Down wrap and borrow:
  - Stimulus: load d=0x01, then en=1, up=0.
  - Required: q = 0x01, 0x00 (tc=1), 0x99, 0x98.
  - Stimulus: load 0x10, then one down step.
  - Required: q = 0x09.
- Illegal load:
  - Stimulus: load d=0x5C.
  - Required: q = 0x50, err=1.
  - Stimulus: 3 more loads of legal values.
  - Required: err stays 1.
  - Stimulus: clr_err=1 together with load d=0xF3.
  - Required: q = 0x03, err stays 1.
  - Stimulus: clr_err=1 alone.
  - Required: err=0.
- Priority:
  - Stimulus: load=1, en=1, d=0x42.
  - Required: q = 0x42, no increment.
  - Stimulus: rst_n=0, load=1, en=1 at count 0x77.
  - Required: q = 0x00, err=0.
  - Stimulus: en=0 for 5 cycles.
  - Required: q holds, tc=0.
- Decoder integration:
  - Stimulus: drive digit 0 into SN74145 and count 0..9.
  - Required: exactly one decoder output is active per cycle, stepping o[0] through o[9] in order.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// ============================================================================
// Module   : bcd_updown_counter
// Purpose  : Multi-digit BCD up/down counter with load, enable and terminal count
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_updown_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  clr_err,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  err
);

  localparam int         W         = 4 * DIGITS;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  logic [W-1:0] q_q, q_d;
  logic         err_q, err_d;

  logic [W-1:0] load_val;
  logic         load_bad;
  logic [W-1:0] step_val;
  logic         ripple;
  logic [3:0]   dig;
  logic         all_max;
  logic         all_zero;

  // Illegal digits are replaced by 0 so the downstream decoder never sees 10-15.
  always_comb begin
    load_val = '0;
    load_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (d[4*k +: 4] > MAX_DIGIT) begin
        load_bad = 1'b1;
      end else begin
        load_val[4*k +: 4] = d[4*k +: 4];
      end
    end
  end

  always_comb begin
    step_val = q_q;
    ripple   = 1'b1;
    dig      = 4'd0;
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      dig = q_q[4*k +: 4];
      if (dig != MAX_DIGIT) all_max  = 1'b0;
      if (dig != 4'd0)      all_zero = 1'b0;
      if (ripple) begin
        if (up) begin
          if (dig == MAX_DIGIT) begin
            step_val[4*k +: 4] = 4'd0;
          end else begin
            step_val[4*k +: 4] = dig + 4'd1;
            ripple             = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step_val[4*k +: 4] = MAX_DIGIT;
          end else begin
            step_val[4*k +: 4] = dig - 4'd1;
            ripple             = 1'b0;
          end
        end
      end
    end
  end

  // An illegal load on the same edge as clr_err keeps err set.
  always_comb begin
    q_d   = q_q;
    err_d = err_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = step_val;
    end
    if (load && load_bad) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign q   = q_q;
  assign err = err_q;
  assign tc  = en & ((up & all_max) | (~up & all_zero));

endmodule

`default_nettype wire
